// File: rtl/seq_age_pkg.sv
// Shared helpers for the sequence-number age tracker.
// age_adj ranks a number by its distance from the oldest in-flight entry.
package seq_age_pkg;

    localparam int LANE_MAX   = 4;
    localparam int LANE_CNT_W = 3;

    // Distance of x from tail, modulo 2**width (width up to 32).
    function automatic logic [31:0] age_adj(
        input logic [31:0] x,
        input logic [31:0] tail,
        input int          width
    );
        logic [31:0] mask;
        if (width >= 32) begin
            mask = '1;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return (x - tail) & mask;
    endfunction

    // Number of consecutive set bits starting at lane 0.
    function automatic logic [LANE_CNT_W-1:0] lead_ones(
        input logic [LANE_MAX-1:0] v
    );
        logic [LANE_CNT_W-1:0] n;
        logic                  run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < LANE_MAX; i++) begin
            run = run & v[i];
            if (run) begin
                n = n + LANE_CNT_W'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_age_cmp.sv
// One age-compare channel: a_older is 1 when a is strictly older than b.
// Ports: a, b (operands), tail (oldest in flight), a_older (result).
module seq_age_cmp
    import seq_age_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] tail,
    output logic         a_older
);

    logic [31:0] adj_a;
    logic [31:0] adj_b;

    assign adj_a   = age_adj(32'(a), 32'(tail), W);
    assign adj_b   = age_adj(32'(b), 32'(tail), W);
    assign a_older = adj_a < adj_b;

endmodule

// File: rtl/seq_age_tracker.sv
// Sequence-number allocator / retirer / age comparator beside the ROB.
// Ports: clk, rst (async active-low); alloc_val/rdy/seq_num (dispatch);
//   commit_val/seq_num (in-order retire lanes); squash_val/seq_num
//   (rollback); cmp_a/cmp_b/cmp_a_older (age queries); oldest_seq_num,
//   empty, full; err (sticky protocol error, built only when
//   SEQ_AGE_TRACKER_CHECK_EN is defined, otherwise tied to 0).
module seq_age_tracker
    import seq_age_pkg::*;
#(
    parameter int p_seq_num_bits = 5,
    parameter int p_num_commit   = 2,
    parameter int p_num_cmp      = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 alloc_val,
    output logic                                 alloc_rdy,
    output logic [p_seq_num_bits-1:0]            alloc_seq_num,
    input  logic [p_num_commit-1:0]              commit_val,
    input  logic [p_num_commit*p_seq_num_bits-1:0] commit_seq_num,
    input  logic                                 squash_val,
    input  logic [p_seq_num_bits-1:0]            squash_seq_num,
    input  logic [p_num_cmp*p_seq_num_bits-1:0]  cmp_a,
    input  logic [p_num_cmp*p_seq_num_bits-1:0]  cmp_b,
    output logic [p_num_cmp-1:0]                 cmp_a_older,
    output logic [p_seq_num_bits-1:0]            oldest_seq_num,
    output logic                                 empty,
    output logic                                 full,
    output logic                                 err
);

    localparam int         B        = p_seq_num_bits;
    localparam logic [B:0] FULL_CNT = {1'b1, {B{1'b0}}};

    logic [B-1:0]          head_q, head_d;
    logic [B-1:0]          tail_q, tail_d;
    logic [B:0]            cnt_q, cnt_d;
    logic [LANE_MAX-1:0]   cv_pad;
    logic [LANE_CNT_W-1:0] n;
    logic [B:0]            n_ext;
    logic [B-1:0]          n_ptr;
    logic [B-1:0]          head_m1;
    logic                  fire;

    assign cv_pad  = LANE_MAX'(commit_val);
    assign n       = lead_ones(cv_pad);
    assign n_ext   = (B+1)'(n);
    assign n_ptr   = B'(n);
    assign head_m1 = head_q - B'(1);

    assign full           = cnt_q == FULL_CNT;
    assign empty          = cnt_q == '0;
    assign alloc_rdy      = !full && !squash_val;
    assign fire           = alloc_val && alloc_rdy;
    assign alloc_seq_num  = head_q;
    assign oldest_seq_num = tail_q;

    always_comb begin
        tail_d = tail_q + n_ptr;
        head_d = head_q;
        cnt_d  = cnt_q - n_ext;
        if (squash_val) begin
            // Squash at head-1 discards nothing; recomputing from the
            // pointers would read a full window as empty.
            if (squash_seq_num != head_m1) begin
                head_d = squash_seq_num + B'(1);
                cnt_d  = {1'b0, head_d - tail_d};
            end
        end else if (fire) begin
            head_d = head_q + B'(1);
            cnt_d  = cnt_q - n_ext + (B+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar c = 0; c < p_num_cmp; c++) begin : g_cmp
        seq_age_cmp #(
            .W(B)
        ) u_cmp (
            .a      (cmp_a[c*B +: B]),
            .b      (cmp_b[c*B +: B]),
            .tail   (tail_q),
            .a_older(cmp_a_older[c])
        );
    end

`ifdef SEQ_AGE_TRACKER_CHECK_EN
    logic                err_q, err_d;
    logic [LANE_MAX-1:0] cv_expect;
    logic                bad_contig;
    logic                bad_seq;
    logic                bad_over;
    logic                bad_alloc;
    logic                bad_squash;

    assign cv_expect  = (LANE_MAX'(1) << n) - LANE_MAX'(1);
    assign bad_contig = cv_pad != cv_expect;
    assign bad_over   = n_ext > cnt_q;
    assign bad_alloc  = alloc_val && full;
    // Window is checked before this cycle's commits retire.
    assign bad_squash = squash_val && (squash_seq_num != head_m1)
                     && ({1'b0, squash_seq_num - tail_q} >= cnt_q);

    always_comb begin
        bad_seq = 1'b0;
        for (int i = 0; i < p_num_commit; i++) begin
            if (commit_val[i]
                && commit_seq_num[i*B +: B] != tail_q + B'(i)) begin
                bad_seq = 1'b1;
            end
        end
    end

    assign err_d = err_q | bad_contig | bad_seq | bad_over
                 | bad_alloc | bad_squash;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_commit_seq;
    assign unused_commit_seq = ^commit_seq_num;
    assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_seq_age_tracker.sv
// Randomised and directed bench for seq_age_tracker against a
// queue-based model of the in-flight window.
module tb_seq_age_tracker;

    localparam int     B = 5;
    localparam int     L = 2;
    localparam int     C = 2;
    localparam longint M = longint'(1) << B;

    logic           clk = 1'b0;
    logic           rst;
    logic           alloc_val;
    logic           alloc_rdy;
    logic [B-1:0]   alloc_seq_num;
    logic [L-1:0]   commit_val;
    logic [L*B-1:0] commit_seq_num;
    logic           squash_val;
    logic [B-1:0]   squash_seq_num;
    logic [C*B-1:0] cmp_a;
    logic [C*B-1:0] cmp_b;
    logic [C-1:0]   cmp_a_older;
    logic [B-1:0]   oldest_seq_num;
    logic           empty;
    logic           full;
    logic           err;

    seq_age_tracker #(
        .p_seq_num_bits(B),
        .p_num_commit  (L),
        .p_num_cmp     (C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_val     (alloc_val),
        .alloc_rdy     (alloc_rdy),
        .alloc_seq_num (alloc_seq_num),
        .commit_val    (commit_val),
        .commit_seq_num(commit_seq_num),
        .squash_val    (squash_val),
        .squash_seq_num(squash_seq_num),
        .cmp_a         (cmp_a),
        .cmp_b         (cmp_b),
        .cmp_a_older   (cmp_a_older),
        .oldest_seq_num(oldest_seq_num),
        .empty         (empty),
        .full          (full),
        .err           (err)
    );

    always #5 clk = ~clk;

    longint q[$];
    longint m_head;
    longint ca[C];
    longint cb[C];
    bit     rnd_cmp;
    int     checks;
    int     errs;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint m_tail();
        return (q.size() != 0) ? q[0] : m_head;
    endfunction

    function automatic bit m_older(input longint a, input longint b);
        longint t;
        t = m_tail();
        return ((a - t + M) % M) < ((b - t + M) % M);
    endfunction

    task automatic drive_idle();
        alloc_val      = 1'b0;
        commit_val     = '0;
        commit_seq_num = '0;
        squash_val     = 1'b0;
        squash_seq_num = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        #3;
        rst = 1'b0;
        #1;
        q.delete();
        m_head = 0;
        chk("rst_empty", longint'(empty), 1);
        chk("rst_full", longint'(full), 0);
        chk("rst_rdy", longint'(alloc_rdy), 1);
        chk("rst_seq", longint'(alloc_seq_num), 0);
        chk("rst_oldest", longint'(oldest_seq_num), 0);
        chk("rst_err", longint'(err), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit av, input int n, input bit sv,
                       input longint sq);
        bit full_e;
        alloc_val      = av;
        commit_val     = L'((1 << n) - 1);
        for (int i = 0; i < L; i++)
            commit_seq_num[i*B +: B] = B'((m_tail() + i) % M);
        squash_val     = sv;
        squash_seq_num = B'(sq);
        for (int c = 0; c < C; c++) begin
            if (rnd_cmp) begin
                ca[c] = longint'($urandom % M);
                cb[c] = longint'($urandom % M);
            end
            cmp_a[c*B +: B] = B'(ca[c]);
            cmp_b[c*B +: B] = B'(cb[c]);
        end
        #1;
        full_e = q.size() == M;
        chk("rdy", longint'(alloc_rdy), longint'(!full_e && !sv));
        chk("seq", longint'(alloc_seq_num), m_head);
        chk("oldest", longint'(oldest_seq_num), m_tail());
        chk("empty", longint'(empty), longint'(q.size() == 0));
        chk("full", longint'(full), longint'(full_e));
        for (int c = 0; c < C; c++)
            chk("cmp", longint'(cmp_a_older[c]),
                longint'(m_older(ca[c], cb[c])));
`ifndef SEQ_AGE_TRACKER_CHECK_EN
        chk("err_off", longint'(err), 0);
`endif
        @(posedge clk);
        for (int i = 0; i < n; i++) void'(q.pop_front());
        if (sv) begin
            if (sq != (m_head - 1 + M) % M) begin
                while (q.size() != 0 && q[$] != sq) void'(q.pop_back());
                m_head = (sq + 1) % M;
            end
        end else if (av && !full_e) begin
            q.push_back(m_head);
            m_head = (m_head + 1) % M;
        end
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        checks  = 0;
        errs    = 0;
        rnd_cmp = 1'b1;
        rst     = 1'b1;
        m_head  = 0;
        drive_idle();
        cmp_a = '0;
        cmp_b = '0;
        for (int c = 0; c < C; c++) begin
            ca[c] = 0;
            cb[c] = 0;
        end
        do_reset();

        // Three allocations, then two-lane commit.
        for (int i = 0; i < 3; i++) begin
            alloc_val = 1'b1;
            #1;
            chk("grant", longint'(alloc_seq_num), i);
            cyc(1, 0, 0, 0);
        end
        chk("t1_empty", longint'(empty), 0);
        chk("t1_oldest", longint'(oldest_seq_num), 0);
        cyc(0, 2, 0, 0);
        chk("t2_oldest", longint'(oldest_seq_num), 2);
        rnd_cmp = 1'b0;
        ca[0] = 0; cb[0] = 3;
        ca[1] = 3; cb[1] = 0;
        cyc(0, 0, 0, 0);
        chk("t2_cmp03", longint'(cmp_a_older[0]), 0);
        chk("t2_cmp30", longint'(cmp_a_older[1]), 1);
        rnd_cmp = 1'b1;

        // Fill to full, then alloc+commit together.
        for (int i = 0; i < 31; i++) cyc(1, 0, 0, 0);
        chk("t3_full", longint'(full), 1);
        chk("t3_rdy", longint'(alloc_rdy), 0);
        cyc(1, 1, 0, 0);
        chk("t3_notfull", longint'(full), 0);
        chk("t3_oldest", longint'(oldest_seq_num), 3);
        chk("t3_head", longint'(alloc_seq_num), 2);

        // Squash with a same-cycle commit; then a no-op squash.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
        cyc(0, 2, 0, 0);
        cyc(0, 2, 0, 0);
        cyc(0, 1, 1, 6);
        chk("t4_tail", longint'(oldest_seq_num), 5);
        chk("t4_head", longint'(alloc_seq_num), 7);
        cyc(0, 0, 1, 6);
        chk("t4_nop_tail", longint'(oldest_seq_num), 5);
        chk("t4_nop_head", longint'(alloc_seq_num), 7);
        cyc(0, 2, 0, 0);
        chk("t4_cnt2", longint'(empty), 1);

        // Wrap-around compares with tail at 30.
        do_reset();
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 2, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        chk("t5_tail", longint'(oldest_seq_num), 30);
        rnd_cmp = 1'b0;
        ca[0] = 31; cb[0] = 1;
        ca[1] = 1;  cb[1] = 31;
        cyc(0, 0, 0, 0);
        chk("t5_31v1", longint'(cmp_a_older[0]), 1);
        chk("t5_1v31", longint'(cmp_a_older[1]), 0);
        ca[0] = 30; cb[0] = 30;
        cyc(0, 0, 0, 0);
        chk("t5_eq", longint'(cmp_a_older[0]), 0);
        rnd_cmp = 1'b1;

`ifdef SEQ_AGE_TRACKER_CHECK_EN
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        commit_val = L'(2);
        @(posedge clk);
        #1;
        commit_val = '0;
        chk("t6_err", longint'(err), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_hold", longint'(err), 1);
        rst = 1'b0;
        #1;
        chk("t6_clr", longint'(err), 0);
        @(negedge clk);
        rst = 1'b1;
`endif

        // Random legal traffic with a mid-run reset.
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            int     sz;
            int     n;
            int     k;
            bit     sv;
            bit     av;
            longint sq;
            if (i == 500) do_reset();
            sz = q.size();
            n  = $urandom_range(0, (sz < L) ? sz : L);
            av = ($urandom % 4) != 0;
            sv = 1'b0;
            sq = 0;
            if (sz > n && ($urandom % 8) == 0) begin
                k  = $urandom_range(n, sz - 1);
                sv = 1'b1;
                sq = q[k];
            end
            cyc(av, n, sv, sq);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errs);
        $finish;
    end

endmodule
